// File: rtl/imem_boot_sequencer_pkg.sv
// Shared state encodings and constants for the instruction-memory boot loader.
// Replaces the imem_boot_defs.vh include with a package.
package imem_boot_sequencer_pkg;

    typedef enum logic [2:0] {
        LOAD_HI = 3'd0,
        LOAD_LO = 3'd1,
        CHECK   = 3'd2,
        RUN     = 3'd3,
        ERROR   = 3'd4
    } boot_state_t;

    localparam int BYTES_PER_WORD      = 2;
    localparam int DEFAULT_TIMEOUT_CYC = 1_000_000;

    // A single-cycle timeout still needs a 1-bit counter.
    function automatic int timer_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/boot_timeout_timer.sv
// Inter-byte watchdog: counts while enabled and flags 'expired' once the count
// reaches TIMEOUT_CYC-1; holds there until cleared.
import imem_boot_sequencer_pkg::*;

module boot_timeout_timer #(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 CNT_W = timer_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/imem_boot_sequencer.sv
// UART boot loader for the instruction memory: packs big-endian byte pairs into
// words, holds the CPU in reset until the memory is full. Option: IMEM_BOOT_CHECKSUM_EN.
import imem_boot_sequencer_pkg::*;

module imem_boot_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              reload_req,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    boot_state_t                   state;
    boot_state_t                   next_state;
    logic [7:0]                    hi_byte;
    logic [ADDR_W-1:0]             addr;
    logic [8*BYTES_PER_WORD-1:0]   word_data;
    logic                          latch_hi;
    logic                          write_word;
    logic                          set_err;
    logic                          run_now;
    logic                          timer_clear;
    logic                          timer_en;
    logic                          timer_expired;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]                    xor_acc;
`endif

    assign word_data   = {hi_byte, rx_data};
    assign timer_clear = (next_state != state);
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign timer_en    = (state == LOAD_LO) || (state == CHECK);
`else
    assign timer_en    = (state == LOAD_LO);
`endif

    // Staying in RUN across an edge gates the CPU, giving one cycle of slack after the last write.
    assign run_now   = (state == RUN) && (next_state == RUN);
    assign mem_raddr = load_done ? cpu_pc : '0;

    boot_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        next_state = state;
        latch_hi   = 1'b0;
        write_word = 1'b0;
        set_err    = 1'b0;
        if (reload_req) begin
            next_state = LOAD_HI;
        end else begin
            case (state)
                LOAD_HI: begin
                    if (rx_valid) begin
                        latch_hi   = 1'b1;
                        next_state = LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (rx_valid) begin
                        write_word = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        next_state = (addr == LAST_ADDR) ? CHECK : LOAD_HI;
`else
                        next_state = (addr == LAST_ADDR) ? RUN : LOAD_HI;
`endif
                    end else if (timer_expired) begin
                        set_err    = 1'b1;
                        next_state = LOAD_HI;
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == xor_acc) begin
                            next_state = RUN;
                        end else begin
                            set_err    = 1'b1;
                            next_state = ERROR;
                        end
                    end else if (timer_expired) begin
                        set_err    = 1'b1;
                        next_state = ERROR;
                    end
                end
                ERROR: next_state = ERROR;
`endif
                RUN:     next_state = RUN;
                default: next_state = LOAD_HI;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= LOAD_HI;
            hi_byte      <= '0;
            addr         <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            cpu_rst_n    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_acc      <= '0;
`endif
        end else begin
            state     <= next_state;
            mem_we    <= write_word;
            cpu_rst_n <= run_now;
            load_done <= run_now;
            if (reload_req) begin
                addr         <= '0;
                words_loaded <= '0;
                load_err     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                xor_acc      <= '0;
`endif
            end else begin
                if (latch_hi) begin
                    hi_byte <= rx_data;
                end
                if (write_word) begin
                    mem_waddr    <= addr;
                    mem_wdata    <= DATA_W'(word_data);
                    addr         <= addr + ADDR_W'(1);
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
                    xor_acc      <= xor_acc ^ hi_byte ^ rx_data;
`endif
                end
                if (set_err) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed self-checking bench for imem_boot_sequencer (short timeout for speed).
// Inputs are driven and outputs checked on the falling edge.
module tb_imem_boot_sequencer;

    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 16;
    localparam int WORDS       = 32;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              reload_req;
    logic [ADDR_W-1:0] cpu_pc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int tests_run    = 0;
    int tests_failed = 0;

    // Write scoreboard, sampled at the edge that ends each write pulse.
    logic [DATA_W-1:0] mem_model [WORDS];
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [DATA_W-1:0] last_wdata = '0;
    int                we_count   = 0;

    always #5 CLK = ~CLK;

    imem_boot_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .reload_req  (reload_req),
        .cpu_pc      (cpu_pc),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .cpu_rst_n   (cpu_rst_n),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always @(posedge CLK) begin
        if (mem_we === 1'b1) begin
            mem_model[mem_waddr] = mem_wdata;
            last_waddr           = mem_waddr;
            last_wdata           = mem_wdata;
            we_count             = we_count + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi);
        send_byte(lo);
        @(negedge CLK);
    endtask

    task automatic pulse_reload(input logic with_byte, input logic [7:0] b);
        @(negedge CLK);
        reload_req = 1'b1;
        rx_valid   = with_byte;
        rx_data    = b;
        @(negedge CLK);
        reload_req = 1'b0;
        rx_valid   = 1'b0;
    endtask

    task automatic test_reset();
        logic [48:0] outs;
        RST_N      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        reload_req = 1'b0;
        cpu_pc     = 5'd9;
        #12;
        outs = {mem_we, mem_waddr, mem_wdata, cpu_rst_n, load_done, load_err, words_loaded, mem_raddr, 9'd0};
        tests_run++;
        if (outs !== 49'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got %h expected 0", outs);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_full_load();
        int                base;
        logic [7:0]        hb;
        logic [7:0]        lb;
        logic [DATA_W-1:0] exp_w;
        base = we_count;
        for (int i = 0; i < 2*WORDS; i++) begin
            @(negedge CLK);
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            if (i == 40) begin
                tests_run++;
                if ({cpu_rst_n, load_done} !== 2'b00) begin
                    tests_failed++;
                    $display("[TB] FAIL cpu_held_mid_load: got %b expected 00", {cpu_rst_n, load_done});
                end
            end
        end
        @(negedge CLK);
        rx_valid = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        tests_run++;
        if (load_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL check_wait: load_done got %b expected 0", load_done);
        end
        send_byte(8'h00);
        tests_run++;
        if (load_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL checksum_latency: load_done got %b expected 0", load_done);
        end
`else
        tests_run++;
        if ({mem_we, load_done, mem_waddr, mem_wdata} !== {1'b1, 1'b0, 5'd31, 16'h3E3F}) begin
            tests_failed++;
            $display("[TB] FAIL last_write: got we=%b done=%b addr=%0d data=%h expected we=1 done=0 addr=31 data=3e3f",
                     mem_we, load_done, mem_waddr, mem_wdata);
        end
`endif
        @(negedge CLK);
        tests_run++;
        if ({load_done, cpu_rst_n, mem_we} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL run_entry: got done/rst_n/we=%b expected 110", {load_done, cpu_rst_n, mem_we});
        end
        tests_run++;
        if (words_loaded !== 6'd32 || (we_count - base) !== WORDS) begin
            tests_failed++;
            $display("[TB] FAIL word_count: got words_loaded=%0d writes=%0d expected 32 and 32",
                     words_loaded, we_count - base);
        end
        for (int k = 0; k < WORDS; k++) begin
            hb    = 8'(2*k);
            lb    = 8'(2*k + 1);
            exp_w = {hb, lb};
            tests_run++;
            if (mem_model[k] !== exp_w) begin
                tests_failed++;
                $display("[TB] FAIL word_%0d: got %h expected %h", k, mem_model[k], exp_w);
            end
        end
    endtask

    task automatic test_run_mode();
        int base;
        @(negedge CLK);
        cpu_pc = 5'd7;
        #1;
        tests_run++;
        if (mem_raddr !== 5'd7) begin
            tests_failed++;
            $display("[TB] FAIL raddr_pc7: got %0d expected 7", mem_raddr);
        end
        cpu_pc = 5'd31;
        #1;
        tests_run++;
        if (mem_raddr !== 5'd31) begin
            tests_failed++;
            $display("[TB] FAIL raddr_pc31: got %0d expected 31", mem_raddr);
        end
        base = we_count;
        send_byte(8'hC0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        @(negedge CLK);
        tests_run++;
        if ((we_count - base) !== 0 || load_done !== 1'b1 || words_loaded !== 6'd32) begin
            tests_failed++;
            $display("[TB] FAIL run_ignores_rx: got writes=%0d done=%b words=%0d expected 0 1 32",
                     we_count - base, load_done, words_loaded);
        end
    endtask

    task automatic test_reload_in_run();
        pulse_reload(1'b1, 8'hEE);
        tests_run++;
        if ({cpu_rst_n, load_done, load_err, words_loaded, mem_raddr} !== 14'd0) begin
            tests_failed++;
            $display("[TB] FAIL reload_run: got rst_n=%b done=%b err=%b words=%0d raddr=%0d expected all 0",
                     cpu_rst_n, load_done, load_err, words_loaded, mem_raddr);
        end
        send_word(8'h11, 8'h22);
        tests_run++;
        if (last_waddr !== 5'd0 || last_wdata !== 16'h1122 || words_loaded !== 6'd1) begin
            tests_failed++;
            $display("[TB] FAIL reload_restart: got addr=%0d data=%h words=%0d expected 0 1122 1",
                     last_waddr, last_wdata, words_loaded);
        end
    endtask

    task automatic test_timeout();
        int base;
        base = we_count;
        send_byte(8'hAB);
        repeat (TIMEOUT_CYC - 1) @(negedge CLK);
        tests_run++;
        if (load_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: load_err got %b expected 0", load_err);
        end
        @(negedge CLK);
        tests_run++;
        if (load_err !== 1'b1 || words_loaded !== 6'd1 || (we_count - base) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_hit: got err=%b words=%0d writes=%0d expected 1 1 0",
                     load_err, words_loaded, we_count - base);
        end
        send_word(8'h01, 8'h02);
        tests_run++;
        if (last_waddr !== 5'd1 || last_wdata !== 16'h0102 || (we_count - base) !== 1 || words_loaded !== 6'd2) begin
            tests_failed++;
            $display("[TB] FAIL timeout_resume: got addr=%0d data=%h writes=%0d words=%0d expected 1 0102 1 2",
                     last_waddr, last_wdata, we_count - base, words_loaded);
        end
    endtask

    task automatic test_reload_mid_load();
        int base;
        base = we_count;
        for (int w = 2; w < 10; w++) begin
            send_word(8'(w), 8'(w + 8'h80));
        end
        tests_run++;
        if (words_loaded !== 6'd10) begin
            tests_failed++;
            $display("[TB] FAIL mid_count: words_loaded got %0d expected 10", words_loaded);
        end
        send_byte(8'h99);
        pulse_reload(1'b1, 8'h9A);
        @(negedge CLK);
        tests_run++;
        if ((we_count - base) !== 8 || words_loaded !== 6'd0 || load_err !== 1'b0 || cpu_rst_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reload_mid: got writes=%0d words=%0d err=%b rst_n=%b expected 8 0 0 0",
                     we_count - base, words_loaded, load_err, cpu_rst_n);
        end
        send_word(8'h55, 8'h66);
        tests_run++;
        if (last_waddr !== 5'd0 || last_wdata !== 16'h5566) begin
            tests_failed++;
            $display("[TB] FAIL reload_mid_restart: got addr=%0d data=%h expected 0 5566", last_waddr, last_wdata);
        end
    endtask

    task automatic test_async_reset();
        logic [41:0] outs;
        for (int w = 1; w < 5; w++) begin
            send_word(8'(8'h10 + w), 8'(8'h20 + w));
        end
        tests_run++;
        if (words_loaded !== 6'd5) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_count: words_loaded got %0d expected 5", words_loaded);
        end
        send_byte(8'hC5);
        #2;
        RST_N = 1'b0;
        #1;
        outs = {mem_we, mem_waddr, mem_wdata, cpu_rst_n, load_done, load_err, words_loaded, mem_raddr, 2'd0};
        tests_run++;
        if (outs !== 42'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h expected 0", outs);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        send_word(8'h77, 8'h88);
        tests_run++;
        if (last_waddr !== 5'd0 || last_wdata !== 16'h7788 || words_loaded !== 6'd1) begin
            tests_failed++;
            $display("[TB] FAIL reset_restart: got addr=%0d data=%h words=%0d expected 0 7788 1",
                     last_waddr, last_wdata, words_loaded);
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        pulse_reload(1'b0, 8'h00);
        for (int i = 0; i < 2*WORDS; i++) begin
            @(negedge CLK);
            rx_valid = 1'b1;
            rx_data  = 8'(i);
        end
        @(negedge CLK);
        rx_valid = 1'b0;
        send_byte(8'h5A);
        tests_run++;
        if (load_err !== 1'b1 || cpu_rst_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL checksum_bad: got err=%b rst_n=%b expected 1 0", load_err, cpu_rst_n);
        end
        send_byte(8'h00);
        repeat (4) @(negedge CLK);
        tests_run++;
        if (load_err !== 1'b1 || cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL error_sticky: got err=%b rst_n=%b done=%b expected 1 0 0",
                     load_err, cpu_rst_n, load_done);
        end
        pulse_reload(1'b0, 8'h00);
        tests_run++;
        if (load_err !== 1'b0 || words_loaded !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL error_reload: got err=%b words=%0d expected 0 0", load_err, words_loaded);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_run_mode();
        test_reload_in_run();
        test_timeout();
        test_reload_mid_load();
        test_async_reset();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
